sa_out_drain: RTL and testbench
===============================

# sa_out_drain

Ping-pong result buffer on the output side of the systolic-array wrapper. It captures the full SA_R×SA_C result tile when the array raises its output-valid. It then streams the tile row by row to the downstream consumer (softmax/accumulator) over a valid/ready handshake. Meanwhile the array may compute and deliver the next tile. It back-pressures the tile sequencer through a ready flag and reports dropped tiles.

## Interface
- D_W, 8: element width in bits.
- SA_R, 16: rows per tile; also the number of row beats per tile.
- SA_C, 16: elements per row.
- I_CLK  in  1  clock; all state changes on the rising edge.
- I_RST_N  in  1  reset, asynchronous, active-low.
- I_OUT_VLD  in  1  result-valid from the array; a tile is presented while it is high.
- I_OUT  in  [D_W-1:0] [0:SA_R-1][0:SA_C-1]  result tile from the array.
- O_SA_RDY  out  1  at least one bank is free; the sequencer issues a start only when this is 1.
- O_ROW_VLD  out  1  O_ROW holds a valid row.
- I_ROW_RDY  in  1  downstream accepts the row.
- O_ROW  out  [D_W-1:0] [0:SA_C-1]  current row, column 0 first.
- O_ROW_IDX  out  $clog2(SA_R)  row index 0..SA_R-1 within the tile.
- O_ROW_LAST  out  1  O_ROW_VLD and O_ROW_IDX==SA_R-1.
- O_OVERFLOW  out  1  sticky: a tile arrived while both banks were full.
- I_CLR_OVF  in  1  clears O_OVERFLOW.
- O_TILE_CNT  out  16  count of captured tiles; wraps 0xFFFF→0.

## Operation
- Storage: two banks, each SA_R×SA_C×D_W. Per-bank full flag. Write pointer wr_sel and read pointer rd_sel, 1 bit each. Row counter row_cnt.
- Capture event: I_OUT_VLD=1 and vld_d=0, where vld_d is I_OUT_VLD registered. An I_OUT_VLD level held high produces exactly one capture.
- On a capture event:
  - If bank[wr_sel] is not full: store the whole I_OUT into it in a single cycle, set its full flag, toggle wr_sel, and increment O_TILE_CNT.
  - Otherwise: drop the tile, leave the banks untouched, and set O_OVERFLOW.
- The free/full decision uses the flags as they stand before the edge. A bank released on the same edge does not accept that capture; the capture is dropped.
- Read side:
  - O_ROW_VLD = full[rd_sel].
  - O_ROW = bank[rd_sel][row_cnt] when valid, all-zero otherwise.
  - O_ROW_IDX = row_cnt.
- On a transfer (O_ROW_VLD & I_ROW_RDY), row_cnt increments. On the transfer with row_cnt==SA_R-1:
  - clear full[rd_sel];
  - toggle rd_sel;
  - set row_cnt to 0.
- O_ROW, O_ROW_IDX and O_ROW_LAST hold stable while O_ROW_VLD=1 and I_ROW_RDY=0. A bank being filled never aliases the bank being read.
- O_SA_RDY = !(full[0] & full[1]). It is combinational from registered flags.
- Overflow:
  - I_CLR_OVF clears O_OVERFLOW.
  - A new drop on the same edge wins, so O_OVERFLOW stays 1.

## Timing
- Reset (I_RST_N low, asynchronous) gives: banks empty, wr_sel=rd_sel=0, row_cnt=0, vld_d=0, O_ROW_VLD=0, O_ROW=0, O_ROW_IDX=0, O_ROW_LAST=0, O_OVERFLOW=0, O_TILE_CNT=0, O_SA_RDY=1. Bank data contents are don't-care.
- Capture at edge N makes O_ROW_VLD=1 in the cycle after edge N. This is 1-cycle latency when the read bank was empty.
- With I_ROW_RDY held 1, a tile drains in exactly SA_R cycles, one row per cycle.
- When both banks are full, the next bank becomes available one cycle after the final row handshake. The tile following it is presented in the cycle after that release edge.
- A capture and a read release on the same edge both take effect, on different banks.
- Reset asserted mid-drain discards both banks immediately. Rows not yet transferred are lost. After reset deassertion an I_OUT_VLD already high counts as a new capture event, because vld_d=0.
- An I_OUT change while I_OUT_VLD stays high is ignored.

## Test plan
- Single tile with I_OUT[r][c]=r*16+c and I_ROW_RDY=1 → O_ROW_VLD on the cycle after capture. 16 consecutive beats follow, where row r carries values r*16..r*16+15. O_ROW_LAST appears only at idx 15. O_TILE_CNT=1, and O_SA_RDY stays 1 throughout.
- Backpressure: I_ROW_RDY toggles 1,0,0,1,… → each row is transferred exactly once. O_ROW and O_ROW_IDX hold stable through the stall cycles, and no row is skipped or repeated.
- Ping-pong: tile A (all 0x01) is captured, then tile B (all 0x20) is captured while A drains. → A's 16 rows are output, then B's 16 rows. O_SA_RDY falls to 0 only while both banks are full, and O_TILE_CNT=2.
- Overflow: three captures with I_ROW_RDY=0 → the third is dropped, O_OVERFLOW=1, O_TILE_CNT=2, and the banks still hold A and B. Then pulse I_CLR_OVF → O_OVERFLOW=0. Also assert I_CLR_OVF on the same edge as a fourth dropped capture → O_OVERFLOW remains 1.
- I_OUT_VLD held high for 20 cycles with changing I_OUT → exactly one capture, holding the first-cycle data, and O_TILE_CNT=1.
- Reset mid-drain after 5 rows → all outputs return to their reset values and O_SA_RDY=1. Then I_OUT_VLD is held high across deassertion → one capture, whose rows start at idx 0.

Source files
------------

// File: rtl/sa_out_drain.sv
// Ping-pong result buffer behind the systolic array: captures whole SA_R x SA_C tiles
// on the rising edge of I_OUT_VLD and drains them row by row over valid/ready.

module sa_out_bank #(
    parameter int D_W  = 8,
    parameter int SA_R = 16,
    parameter int SA_C = 16,
    parameter int RW   = 4
) (
    input  logic                                  I_CLK,
    input  logic                                  we,
    input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    tile,
    input  logic [RW-1:0]                         row_sel,
    output logic [0:SA_C-1][D_W-1:0]              row
);
    // Data storage carries no reset; validity lives in the owner's full flags.
    logic [0:SA_R-1][0:SA_C-1][D_W-1:0] mem;

    always_ff @(posedge I_CLK) begin
        if (we) mem <= tile;
    end

    assign row = mem[row_sel];
endmodule

module sa_out_drain #(
    parameter int D_W  = 8,
    parameter int SA_R = 16,
    parameter int SA_C = 16
) (
    input  logic                                  I_CLK,
    input  logic                                  I_RST_N,
    input  logic                                  I_OUT_VLD,
    input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    I_OUT,
    output logic                                  O_SA_RDY,
    output logic                                  O_ROW_VLD,
    input  logic                                  I_ROW_RDY,
    output logic [0:SA_C-1][D_W-1:0]              O_ROW,
    output logic [$clog2(SA_R)-1:0]               O_ROW_IDX,
    output logic                                  O_ROW_LAST,
    output logic                                  O_OVERFLOW,
    input  logic                                  I_CLR_OVF,
    output logic [15:0]                           O_TILE_CNT
);
    localparam int RW = $clog2(SA_R);
    localparam logic [RW-1:0] LAST_ROW = RW'(SA_R - 1);

    logic [1:0]                        full, full_nxt;
    logic                              wr_sel, rd_sel, vld_d;
    logic [RW-1:0]                     row_cnt;
    logic [1:0][0:SA_C-1][D_W-1:0]     bank_row;
    logic                              cap, cap_ok, cap_drop, xfer, last_xfer;

    assign cap       = I_OUT_VLD & ~vld_d;
    assign cap_ok    = cap & ~full[wr_sel];
    assign cap_drop  = cap &  full[wr_sel];
    assign xfer      = full[rd_sel] & I_ROW_RDY;
    assign last_xfer = xfer & (row_cnt == LAST_ROW);

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            localparam logic BSEL = 1'(b);
            sa_out_bank #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .RW(RW)) u_bank (
                .I_CLK   (I_CLK),
                .we      (cap_ok && (wr_sel == BSEL)),
                .tile    (I_OUT),
                .row_sel (row_cnt),
                .row     (bank_row[b])
            );
        end
    endgenerate

    // Flags sampled before the edge decide capture, so a bank freed this edge
    // cannot take this edge's tile; cap_ok and last_xfer never hit the same bank.
    always_comb begin
        full_nxt = full;
        if (last_xfer) full_nxt[rd_sel] = 1'b0;
        if (cap_ok)    full_nxt[wr_sel] = 1'b1;
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            full       <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            vld_d      <= 1'b0;
            row_cnt    <= '0;
            O_OVERFLOW <= 1'b0;
            O_TILE_CNT <= '0;
        end else begin
            full  <= full_nxt;
            vld_d <= I_OUT_VLD;
            if (cap_ok) begin
                wr_sel     <= ~wr_sel;
                O_TILE_CNT <= O_TILE_CNT + 16'd1;
            end
            if (last_xfer) begin
                rd_sel  <= ~rd_sel;
                row_cnt <= '0;
            end else if (xfer) begin
                row_cnt <= row_cnt + 1'b1;
            end
            if (cap_drop)       O_OVERFLOW <= 1'b1;
            else if (I_CLR_OVF) O_OVERFLOW <= 1'b0;
        end
    end

    assign O_SA_RDY   = ~(full[0] & full[1]);
    assign O_ROW_VLD  = full[rd_sel];
    assign O_ROW      = O_ROW_VLD ? bank_row[rd_sel] : '0;
    assign O_ROW_IDX  = row_cnt;
    assign O_ROW_LAST = O_ROW_VLD & (row_cnt == LAST_ROW);
endmodule

// File: tb/tb_sa_out_drain.sv
// Directed bench for sa_out_drain: per-cycle vector table for a single tile, plus
// sequences for backpressure, ping-pong, overflow, held valid and reset mid-drain.

module tb_sa_out_drain;
    logic                         I_CLK = 1'b0;
    logic                         I_RST_N;
    logic                         I_OUT_VLD;
    logic [0:15][0:15][7:0]       I_OUT;
    logic                         O_SA_RDY;
    logic                         O_ROW_VLD;
    logic                         I_ROW_RDY;
    logic [0:15][7:0]             O_ROW;
    logic [3:0]                   O_ROW_IDX;
    logic                         O_ROW_LAST;
    logic                         O_OVERFLOW;
    logic                         I_CLR_OVF;
    logic [15:0]                  O_TILE_CNT;

    int checks = 0;
    int errors = 0;

    sa_out_drain #(.D_W(8), .SA_R(16), .SA_C(16)) dut (
        .I_CLK      (I_CLK),
        .I_RST_N    (I_RST_N),
        .I_OUT_VLD  (I_OUT_VLD),
        .I_OUT      (I_OUT),
        .O_SA_RDY   (O_SA_RDY),
        .O_ROW_VLD  (O_ROW_VLD),
        .I_ROW_RDY  (I_ROW_RDY),
        .O_ROW      (O_ROW),
        .O_ROW_IDX  (O_ROW_IDX),
        .O_ROW_LAST (O_ROW_LAST),
        .O_OVERFLOW (O_OVERFLOW),
        .I_CLR_OVF  (I_CLR_OVF),
        .O_TILE_CNT (O_TILE_CNT)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic         vld;
        logic         rdy;
        logic         clr;
        logic         exp_vld;
        logic [3:0]   exp_idx;
        logic         exp_last;
        logic         exp_sardy;
        logic         exp_ovf;
        logic [15:0]  exp_cnt;
        logic [127:0] exp_row;
    } vec_t;

    vec_t vecs [0:16];

    // pat 0: element [r][c] = r*16+c; any other pat: every element = pat
    function automatic logic [127:0] row_pat(input int pat, input int r);
        logic [0:15][7:0] v;
        for (int c = 0; c < 16; c++) v[c] = (pat == 0) ? 8'(r * 16 + c) : 8'(pat);
        return v;
    endfunction

    function automatic logic [0:15][0:15][7:0] mk_tile(input int pat);
        logic [0:15][0:15][7:0] t;
        for (int r = 0; r < 16; r++) t[r] = row_pat(pat, r);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge I_CLK);
        #1;
    endtask

    task automatic do_reset;
        I_RST_N = 1'b0;
        I_OUT_VLD = 1'b0;
        I_ROW_RDY = 1'b0;
        I_CLR_OVF = 1'b0;
        step();
        I_RST_N = 1'b1;
    endtask

    task automatic pulse_cap(input int pat);
        I_OUT = mk_tile(pat);
        I_OUT_VLD = 1'b1;
        step();
        I_OUT_VLD = 1'b0;
        step();
    endtask

    // Drains with ready held high; tiles hold pat0 then pat1 back to back.
    task automatic drain(input int pat0, input int pat1, input int ntiles);
        int n;
        n = 0;
        I_ROW_RDY = 1'b1;
        for (int cyc = 0; cyc < 100 && n < ntiles * 16; cyc++) begin
            chk("drain_vld", 128'(O_ROW_VLD), 128'(1));
            chk("drain_idx", 128'(O_ROW_IDX), 128'(n % 16));
            chk("drain_row", O_ROW, row_pat((n < 16) ? pat0 : pat1, n % 16));
            chk("drain_last", 128'(O_ROW_LAST), 128'((n % 16) == 15));
            step();
            n++;
        end
        chk("drain_done_vld", 128'(O_ROW_VLD), 128'(0));
        chk("drain_done_row", O_ROW, 128'(0));
        I_ROW_RDY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_idx;
        logic rdy;

        // vector table: single ramp tile with ready held high
        vecs[0] = '{vld:1, rdy:1, clr:0, exp_vld:1, exp_idx:0, exp_last:0, exp_sardy:1,
                    exp_ovf:0, exp_cnt:1, exp_row:row_pat(0, 0)};
        for (int k = 1; k < 16; k++)
            vecs[k] = '{vld:0, rdy:1, clr:0, exp_vld:1, exp_idx:4'(k), exp_last:(k == 15),
                        exp_sardy:1, exp_ovf:0, exp_cnt:1, exp_row:row_pat(0, k)};
        vecs[16] = '{vld:0, rdy:1, clr:0, exp_vld:0, exp_idx:0, exp_last:0, exp_sardy:1,
                     exp_ovf:0, exp_cnt:1, exp_row:128'(0)};

        I_RST_N = 1'b0;
        I_OUT_VLD = 1'b0;
        I_ROW_RDY = 1'b0;
        I_CLR_OVF = 1'b0;
        I_OUT = '0;
        step();
        step();
        chk("rst_vld", 128'(O_ROW_VLD), 128'(0));
        chk("rst_row", O_ROW, 128'(0));
        chk("rst_idx", 128'(O_ROW_IDX), 128'(0));
        chk("rst_last", 128'(O_ROW_LAST), 128'(0));
        chk("rst_ovf", 128'(O_OVERFLOW), 128'(0));
        chk("rst_cnt", 128'(O_TILE_CNT), 128'(0));
        chk("rst_sardy", 128'(O_SA_RDY), 128'(1));
        I_RST_N = 1'b1;
        step();

        // single tile
        I_OUT = mk_tile(0);
        for (int i = 0; i < 17; i++) begin
            I_OUT_VLD = vecs[i].vld;
            I_ROW_RDY = vecs[i].rdy;
            I_CLR_OVF = vecs[i].clr;
            step();
            chk("vec_vld", 128'(O_ROW_VLD), 128'(vecs[i].exp_vld));
            chk("vec_idx", 128'(O_ROW_IDX), 128'(vecs[i].exp_idx));
            chk("vec_last", 128'(O_ROW_LAST), 128'(vecs[i].exp_last));
            chk("vec_sardy", 128'(O_SA_RDY), 128'(vecs[i].exp_sardy));
            chk("vec_ovf", 128'(O_OVERFLOW), 128'(vecs[i].exp_ovf));
            chk("vec_cnt", 128'(O_TILE_CNT), 128'(vecs[i].exp_cnt));
            chk("vec_row", O_ROW, vecs[i].exp_row);
        end
        I_ROW_RDY = 1'b0;

        // backpressure: ready pattern 1,0,0 repeating
        do_reset();
        I_OUT = mk_tile(0);
        I_OUT_VLD = 1'b1;
        step();
        I_OUT_VLD = 1'b0;
        exp_idx = 0;
        for (int cyc = 0; cyc < 100 && exp_idx < 16; cyc++) begin
            chk("bp_vld", 128'(O_ROW_VLD), 128'(1));
            chk("bp_idx", 128'(O_ROW_IDX), 128'(exp_idx));
            chk("bp_row", O_ROW, row_pat(0, exp_idx));
            chk("bp_last", 128'(O_ROW_LAST), 128'(exp_idx == 15));
            rdy = ((cyc % 3) == 0);
            I_ROW_RDY = rdy;
            step();
            if (rdy) exp_idx++;
        end
        chk("bp_done_vld", 128'(O_ROW_VLD), 128'(0));
        chk("bp_cnt", 128'(O_TILE_CNT), 128'(1));
        I_ROW_RDY = 1'b0;

        // ping-pong: A (0x01) drains while B (0x20) arrives
        do_reset();
        I_OUT = mk_tile(8'h01);
        I_OUT_VLD = 1'b1;
        I_ROW_RDY = 1'b1;
        step();
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 32; cyc++) begin
            chk("pp_vld", 128'(O_ROW_VLD), 128'(1));
            chk("pp_idx", 128'(O_ROW_IDX), 128'(n % 16));
            chk("pp_row", O_ROW, row_pat((n < 16) ? 8'h01 : 8'h20, n % 16));
            chk("pp_sardy", 128'(O_SA_RDY), 128'(!(n >= 2 && n <= 15)));
            I_OUT_VLD = (cyc == 1);
            if (cyc == 1) I_OUT = mk_tile(8'h20);
            step();
            n++;
        end
        chk("pp_done_vld", 128'(O_ROW_VLD), 128'(0));
        chk("pp_cnt", 128'(O_TILE_CNT), 128'(2));
        chk("pp_sardy_end", 128'(O_SA_RDY), 128'(1));
        I_OUT_VLD = 1'b0;
        I_ROW_RDY = 1'b0;

        // overflow with ready low, clear, then clear colliding with a drop
        do_reset();
        pulse_cap(8'h01);
        chk("ov_sardy1", 128'(O_SA_RDY), 128'(1));
        pulse_cap(8'h20);
        chk("ov_none", 128'(O_OVERFLOW), 128'(0));
        chk("ov_sardy2", 128'(O_SA_RDY), 128'(0));
        pulse_cap(8'h33);
        chk("ov_set", 128'(O_OVERFLOW), 128'(1));
        chk("ov_cnt", 128'(O_TILE_CNT), 128'(2));
        I_CLR_OVF = 1'b1;
        step();
        I_CLR_OVF = 1'b0;
        chk("ov_clr", 128'(O_OVERFLOW), 128'(0));
        I_OUT = mk_tile(8'h44);
        I_OUT_VLD = 1'b1;
        I_CLR_OVF = 1'b1;
        step();
        chk("ov_drop_wins", 128'(O_OVERFLOW), 128'(1));
        I_OUT_VLD = 1'b0;
        I_CLR_OVF = 1'b0;
        step();
        chk("ov_cnt2", 128'(O_TILE_CNT), 128'(2));
        drain(8'h01, 8'h20, 2);

        // valid held 20 cycles with changing data: one capture of first-cycle data
        do_reset();
        I_OUT_VLD = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            I_OUT = mk_tile((cyc == 0) ? 0 : cyc + 5);
            step();
        end
        I_OUT_VLD = 1'b0;
        step();
        chk("hold_cnt", 128'(O_TILE_CNT), 128'(1));
        chk("hold_sardy", 128'(O_SA_RDY), 128'(1));
        chk("hold_ovf", 128'(O_OVERFLOW), 128'(0));
        drain(0, 0, 1);

        // reset mid-drain after 5 rows, valid held high across deassertion
        do_reset();
        I_OUT = mk_tile(0);
        I_OUT_VLD = 1'b1;
        I_ROW_RDY = 1'b1;
        step();
        I_OUT_VLD = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_idx", 128'(O_ROW_IDX), 128'(5));
        I_ROW_RDY = 1'b0;
        I_RST_N = 1'b0;
        #1;
        chk("mid_rst_vld", 128'(O_ROW_VLD), 128'(0));
        chk("mid_rst_row", O_ROW, 128'(0));
        chk("mid_rst_idx", 128'(O_ROW_IDX), 128'(0));
        chk("mid_rst_last", 128'(O_ROW_LAST), 128'(0));
        chk("mid_rst_cnt", 128'(O_TILE_CNT), 128'(0));
        chk("mid_rst_ovf", 128'(O_OVERFLOW), 128'(0));
        chk("mid_rst_sardy", 128'(O_SA_RDY), 128'(1));
        I_OUT = mk_tile(8'h5A);
        I_OUT_VLD = 1'b1;
        step();
        step();
        I_RST_N = 1'b1;
        step();
        chk("post_vld", 128'(O_ROW_VLD), 128'(1));
        chk("post_idx", 128'(O_ROW_IDX), 128'(0));
        chk("post_row", O_ROW, row_pat(8'h5A, 0));
        chk("post_cnt", 128'(O_TILE_CNT), 128'(1));
        step();
        I_OUT_VLD = 1'b0;
        chk("post_cnt_held", 128'(O_TILE_CNT), 128'(1));
        drain(8'h5A, 8'h5A, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
